fractal_sync_node: RTL and testbench

- Responder end of the fractal sync protocol: one binary tree node that receives barrier requests from two children (tile decoders or lower nodes) and either wakes them as the barrier root or forwards a merged request to its parent.
- Instantiated at every level of the horizontal and vertical sync trees; children connect to tile decoder mst ports, parent port to the next level's child port.

---
 rtl/fractal_sync_node.sv | 162 ++++++++++++++++
 tb/tb_fractal_sync_node.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_node.sv
// Fractal sync tree node: merges barrier requests from two children and either wakes
// them as the barrier root or forwards one merged request to the parent.
module fractal_sync_node #(
    parameter int unsigned AGGR_W  = 8,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [1:0]            c_sync_i,
    input  logic [2*AGGR_W-1:0]   c_aggr_i,
    input  logic [2*ID_W-1:0]     c_id_i,
    output logic [1:0]            c_wake_o,
    output logic [1:0]            c_error_o,
    output logic                  p_sync_o,
    output logic [AGGR_W-1:0]     p_aggr_o,
    output logic [ID_W-1:0]       p_id_o,
    input  logic                  p_wake_i,
    input  logic                  p_error_i
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitPeer,
        StFwd,
        StWaitParent,
        StWake,
        StErr
    } state_e;

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_valid;
    logic [AGGR_W-1:0]  r_aggr0, r_aggr1;
    logic [ID_W-1:0]    r_id0, r_id1;
    logic [1:0]         r_wake, r_err;
    logic               r_psync;
    logic [AGGR_W-1:0]  r_paggr;
    logic [ID_W-1:0]    r_pid;

    logic               w_accept;
    logic [1:0]         w_cap, w_viol, w_valid_n;
    logic [AGGR_W-1:0]  w_aggr0, w_aggr1;
    logic [ID_W-1:0]    w_id0, w_id1;
    logic               w_match, w_root, w_timeout;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_go_wake, w_go_fwd, w_go_err, w_go_peer;

    // Child syncs in the WAKE/ERR cycle are dropped, neither captured nor flagged.
    assign w_accept  = (r_state != StWake) && (r_state != StErr);
    assign w_cap     = w_accept ? (c_sync_i & ~r_valid) : 2'b00;
    assign w_viol    = w_accept ? (c_sync_i & r_valid) : 2'b00;
    assign w_valid_n = r_valid | w_cap;

    assign w_aggr0 = w_cap[0] ? c_aggr_i[AGGR_W-1:0]        : r_aggr0;
    assign w_aggr1 = w_cap[1] ? c_aggr_i[2*AGGR_W-1:AGGR_W] : r_aggr1;
    assign w_id0   = w_cap[0] ? c_id_i[ID_W-1:0]            : r_id0;
    assign w_id1   = w_cap[1] ? c_id_i[2*ID_W-1:ID_W]       : r_id1;

    assign w_match   = (w_aggr0 == w_aggr1) && (w_id0 == w_id1) && (w_aggr0 != '0);
    assign w_root    = (w_aggr0 == AGGR_W'(1));
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc >= TO_LIMIT);

    always_comb begin
        w_go_wake = 1'b0;
        w_go_fwd  = 1'b0;
        w_go_err  = 1'b0;
        w_go_peer = 1'b0;
        if (((r_state == StIdle) || (r_state == StWaitPeer)) && (w_valid_n == 2'b11)) begin
            if (!w_match) begin
                w_go_err = 1'b1;
            end else if (w_root) begin
                w_go_wake = 1'b1;
            end else begin
                w_go_fwd = 1'b1;
            end
        end else if ((r_state == StIdle) && (w_valid_n != 2'b00)) begin
            w_go_peer = 1'b1;
        end else if ((r_state == StWaitPeer) && w_timeout) begin
            w_go_err = 1'b1;
        end else if (r_state == StWaitParent) begin
            if (p_error_i) begin
                w_go_err = 1'b1;
            end else if (p_wake_i) begin
                w_go_wake = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_valid <= 2'b00;
            r_aggr0 <= '0;
            r_aggr1 <= '0;
            r_id0   <= '0;
            r_id1   <= '0;
            r_wake  <= 2'b00;
            r_err   <= 2'b00;
            r_psync <= 1'b0;
            r_paggr <= '0;
            r_pid   <= '0;
        end else if (clear_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_valid <= 2'b00;
            r_aggr0 <= '0;
            r_aggr1 <= '0;
            r_id0   <= '0;
            r_id1   <= '0;
            r_wake  <= 2'b00;
            r_err   <= 2'b00;
            r_psync <= 1'b0;
            r_paggr <= '0;
            r_pid   <= '0;
        end else begin
            r_aggr0 <= w_aggr0;
            r_aggr1 <= w_aggr1;
            r_id0   <= w_id0;
            r_id1   <= w_id1;
            r_valid <= w_accept ? w_valid_n : 2'b00;
            r_wake  <= w_go_wake ? 2'b11 : 2'b00;
            r_err   <= w_viol | (w_go_err ? w_valid_n : 2'b00);
            r_psync <= w_go_fwd;
            if (w_go_fwd) begin
                r_paggr <= w_aggr0 >> 1;
                r_pid   <= w_id0;
            end
            if (w_go_err) begin
                r_state <= StErr;
            end else if (w_go_wake) begin
                r_state <= StWake;
            end else if (w_go_fwd) begin
                r_state <= StFwd;
            end else if (w_go_peer) begin
                r_state <= StWaitPeer;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    StWaitPeer: r_cnt   <= w_cnt_inc;
                    StFwd:      r_state <= StWaitParent;
                    StWake:     r_state <= StIdle;
                    StErr:      r_state <= StIdle;
                    default:    r_state <= r_state;
                endcase
            end
        end
    end

    assign c_wake_o  = r_wake;
    assign c_error_o = r_err;
    assign p_sync_o  = r_psync;
    assign p_aggr_o  = r_paggr;
    assign p_id_o    = r_pid;

endmodule

// File: tb/tb_fractal_sync_node.sv
// Directed bench for fractal_sync_node: a timestamp-driven barrier model schedules the
// expected outputs per cycle; literal checks pin the key scenarios.
module tb_fractal_sync_node;

    localparam int TO = 8;
    localparam int NCYC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [1:0]  c_sync = 2'b00;
    logic [15:0] c_aggr = '0;
    logic [15:0] c_id = '0;
    logic [1:0]  c_wake, c_error;
    logic        p_sync;
    logic [7:0]  p_aggr, p_id;
    logic        p_wake = 1'b0;
    logic        p_error = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    fractal_sync_node #(
        .AGGR_W (8),
        .ID_W   (8),
        .TIMEOUT(TO),
        .CNT_W  (16)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (clear),
        .c_sync_i (c_sync),
        .c_aggr_i (c_aggr),
        .c_id_i   (c_id),
        .c_wake_o (c_wake),
        .c_error_o(c_error),
        .p_sync_o (p_sync),
        .p_aggr_o (p_aggr),
        .p_id_o   (p_id),
        .p_wake_i (p_wake),
        .p_error_i(p_error)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Model: expected outputs per cycle, filled in when the deciding edge is seen.
    logic [1:0] exp_wake [NCYC];
    logic [1:0] exp_err  [NCYC];
    logic       exp_ps   [NCYC];
    logic [7:0] exp_pa   [NCYC];
    logic [7:0] exp_pi   [NCYC];

    bit         pv [2];
    logic [7:0] pa [2];
    logic [7:0] pid [2];
    bit         in_par;
    int         par_from, quiet_at, deadline;
    logic [1:0] ew, ee;
    logic       es;
    logic [7:0] ea, ei;
    bit         nc;

    always @(posedge clk) begin
        ew = 2'b00; ee = 2'b00; es = 1'b0; ea = 8'h00; ei = 8'h00; nc = 1'b0;
        if (rst || clear) begin
            pv[0] = 0; pv[1] = 0; in_par = 0; quiet_at = -1; deadline = -1; par_from = 0;
        end else if (cyc != quiet_at) begin
            for (int c = 0; c < 2; c++) begin
                if (c_sync[c]) begin
                    if (pv[c]) begin
                        ee[c] = 1'b1;
                    end else begin
                        pv[c] = 1; pa[c] = c_aggr[c*8 +: 8]; pid[c] = c_id[c*8 +: 8]; nc = 1;
                    end
                end
            end
            if (pv[0] && pv[1] && !in_par) begin
                if (pa[0] == pa[1] && pid[0] == pid[1] && pa[0] != 0) begin
                    if (pa[0] == 1) begin
                        ew = 2'b11; pv[0] = 0; pv[1] = 0; quiet_at = cyc + 1;
                    end else begin
                        es = 1'b1; ea = pa[0] / 2; ei = pid[0]; in_par = 1; par_from = cyc + 2;
                    end
                end else begin
                    ee = 2'b11; pv[0] = 0; pv[1] = 0; quiet_at = cyc + 1;
                end
            end else if ((pv[0] ^ pv[1]) && nc) begin
                deadline = cyc + TO - 1;
            end else if ((pv[0] ^ pv[1]) && cyc == deadline) begin
                ee[0] = ee[0] | pv[0]; ee[1] = ee[1] | pv[1];
                pv[0] = 0; pv[1] = 0; quiet_at = cyc + 1;
            end else if (in_par && cyc >= par_from && (p_error || p_wake)) begin
                if (p_error) ee = 2'b11;
                else ew = 2'b11;
                pv[0] = 0; pv[1] = 0; in_par = 0; quiet_at = cyc + 1;
            end
        end
        if (cyc + 1 < NCYC) begin
            exp_wake[cyc+1] = ew; exp_err[cyc+1] = ee; exp_ps[cyc+1] = es;
            exp_pa[cyc+1] = ea; exp_pi[cyc+1] = ei;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc > 0 && cyc < NCYC) begin
            if (rst) begin
                cmp("rst_wake", 32'(c_wake), 0);
                cmp("rst_err", 32'(c_error), 0);
                cmp("rst_psync", 32'(p_sync), 0);
            end else begin
                cmp("wake", 32'(c_wake), 32'(exp_wake[cyc]));
                cmp("error", 32'(c_error), 32'(exp_err[cyc]));
                cmp("psync", 32'(p_sync), 32'(exp_ps[cyc]));
                if (exp_ps[cyc]) begin
                    cmp("paggr", 32'(p_aggr), 32'(exp_pa[cyc]));
                    cmp("pid", 32'(p_id), 32'(exp_pi[cyc]));
                end
            end
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic [7:0] a0, input logic [7:0] i0,
                         input logic [7:0] a1, input logic [7:0] i1);
        c_sync = s;
        c_aggr = {a1, a0};
        c_id   = {i1, i0};
        step(1);
        c_sync = 2'b00;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        cmp("reset_wake", 32'(c_wake), 0);
        cmp("reset_paggr", 32'(p_aggr), 0);
        step(2);

        // Root barrier: left at cycle 0, right at cycle 3 -> wake in cycle 4 only.
        drive(2'b01, 8'd1, 8'd5, 8'd0, 8'd0);
        step(2);
        drive(2'b10, 8'd0, 8'd0, 8'd1, 8'd5);
        cmp("t1_wake", 32'(c_wake), 32'h3);
        step(1);
        cmp("t1_wake_once", 32'(c_wake), 0);
        step(2);

        // Forward then parent wake.
        drive(2'b11, 8'd6, 8'd3, 8'd6, 8'd3);
        cmp("t2_psync", 32'(p_sync), 1);
        cmp("t2_paggr", 32'(p_aggr), 3);
        cmp("t2_pid", 32'(p_id), 3);
        step(9);
        p_wake = 1'b1;
        step(1);
        p_wake = 1'b0;
        cmp("t2_wake", 32'(c_wake), 32'h3);
        step(2);

        // Id mismatch, then confirm the node is idle again.
        drive(2'b01, 8'd1, 8'd2, 8'd0, 8'd0);
        drive(2'b10, 8'd0, 8'd0, 8'd1, 8'd7);
        cmp("t3_err", 32'(c_error), 32'h3);
        cmp("t3_nowake", 32'(c_wake), 0);
        step(1);
        drive(2'b11, 8'd1, 8'd9, 8'd1, 8'd9);
        cmp("t3_recover", 32'(c_wake), 32'h3);
        step(2);

        // Lone left request times out 8 cycles later.
        drive(2'b01, 8'd1, 8'd1, 8'd0, 8'd0);
        step(6);
        cmp("t4_early", 32'(c_error), 0);
        step(1);
        cmp("t4_timeout", 32'(c_error), 32'h1);
        step(1);
        cmp("t4_once", 32'(c_error), 0);
        step(3);

        // WAIT_PARENT: child violation, then wake+error together -> error wins.
        drive(2'b11, 8'd2, 8'd4, 8'd2, 8'd4);
        cmp("t5_paggr", 32'(p_aggr), 1);
        step(1);
        drive(2'b01, 8'd2, 8'd4, 8'd0, 8'd0);
        cmp("t5_viol", 32'(c_error), 32'h1);
        p_wake = 1'b1;
        p_error = 1'b1;
        step(1);
        p_wake = 1'b0;
        p_error = 1'b0;
        cmp("t5_err", 32'(c_error), 32'h3);
        cmp("t5_nowake", 32'(c_wake), 0);
        step(2);

        // Double left sync, then matching right still wakes.
        drive(2'b01, 8'd1, 8'd6, 8'd0, 8'd0);
        step(1);
        drive(2'b01, 8'd1, 8'd6, 8'd0, 8'd0);
        cmp("t6_viol", 32'(c_error), 32'h1);
        step(1);
        drive(2'b10, 8'd0, 8'd0, 8'd1, 8'd6);
        cmp("t6_wake", 32'(c_wake), 32'h3);
        step(2);

        // Reset in WAIT_PEER discards the pending request.
        drive(2'b01, 8'd1, 8'd8, 8'd0, 8'd0);
        step(2);
        rst = 1'b1;
        #1;
        cmp("t6_rst_err", 32'(c_error), 0);
        step(1);
        rst = 1'b0;
        drive(2'b10, 8'd0, 8'd0, 8'd1, 8'd8);
        step(3);
        cmp("t6_no_wake", 32'(c_wake), 0);
        step(8);

        // Clear in WAIT_PARENT: later parent wake is ignored.
        drive(2'b11, 8'd4, 8'd1, 8'd4, 8'd1);
        step(1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        p_wake = 1'b1;
        step(1);
        p_wake = 1'b0;
        cmp("t7_no_wake", 32'(c_wake), 0);
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
